// File: rtl/mem_sram_responder.sv
// mem_sram_responder: MEM-protocol (req/gnt/valid) slave backed by a
// word-addressed array with a fixed response latency and a bound on the
// number of accepted-but-unanswered requests.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   s_mem_req    request valid from master
//   s_mem_gnt    request accepted when req & gnt
//   s_mem_valid  response valid, one cycle per accepted request
//   s_mem_addr   byte address
//   s_mem_we     1 = write, 0 = read
//   s_mem_be     byte enables for writes
//   s_mem_wdata  write data
//   s_mem_rdata  read data, zero whenever s_mem_valid is low
//   oob_error_o  sticky out-of-range access flag, cleared by reset
module mem_sram_responder #(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DEPTH           = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned           LATENCY         = 1,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_mem_req,
  output logic                    s_mem_gnt,
  output logic                    s_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic                    s_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s_mem_be,
  input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
  output logic [DATA_WIDTH-1:0]   s_mem_rdata,
  output logic                    oob_error_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH * 4);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0]      outstanding;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic                  oob_q;

  // Response pipeline: stage 0 is loaded at the accept edge, the last
  // stage drives the outputs. Idle stages carry zero data.
  logic                  pipe_v [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [LATENCY];

  assign s_mem_gnt = !rst_i && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept    = s_mem_req && s_mem_gnt;

  always_comb begin
    offset   = s_mem_addr - BASE_ADDR;
    in_range = (s_mem_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    idx      = offset[IDX_W+1:2];
  end

  // Writes commit at the accept edge, so a read accepted on the next
  // edge already sees the new data.
  always_ff @(posedge clk_i) begin
    if (accept && s_mem_we && in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s_mem_be[b]) mem[idx][8*b +: 8] <= s_mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
      outstanding <= '0;
      oob_q       <= 1'b0;
    end else begin
      pipe_v[0] <= accept;
      pipe_d[0] <= (accept && !s_mem_we && in_range) ? mem[idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      case ({accept, pipe_v[LATENCY-1]})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (accept && !in_range) oob_q <= 1'b1;
    end
  end

  // Outputs read as their reset values for as long as rst_i is held.
  assign s_mem_valid = !rst_i && pipe_v[LATENCY-1];
  assign s_mem_rdata = rst_i ? '0 : pipe_d[LATENCY-1];
  assign oob_error_o = !rst_i && oob_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (outstanding <= CNT_W'(MAX_OUTSTANDING));
      assert (!(pipe_v[LATENCY-1] && outstanding == '0));
    end
  end

endmodule

// File: tb/tb_mem_sram_responder.sv
module tb_mem_sram_responder;

  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        gnt, valid, oob;

  always #5 clk = ~clk;

  mem_sram_responder #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .DEPTH          (DEPTH),
    .BASE_ADDR      (BASE),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_mem_req  (req),
    .s_mem_gnt  (gnt),
    .s_mem_valid(valid),
    .s_mem_addr (addr),
    .s_mem_we   (we),
    .s_mem_be   (be),
    .s_mem_wdata(wdata),
    .s_mem_rdata(rdata),
    .oob_error_o(oob)
  );

  // Reference model: pending responses as (due cycle, data), memory as an
  // associative array of words, sticky error flag.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] ref_mem [int];
  logic        ref_oob = 1'b0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model
  // at the rising edge. Entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic r, input logic rq, input logic w,
                       input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic acc);
    logic        exp_gnt, exp_valid;
    logic [31:0] exp_rdata, off, word;
    int          idx;
    rst = r; req = rq; we = w; addr = a; be = b; wdata = d;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    exp_gnt   = !r && (pend.size() < MAXO);
    exp_valid = !r && pend.size() > 0 && pend[0].due == cyc;
    exp_rdata = exp_valid ? pend[0].data : 32'h0;
    @(negedge clk);
    chk("gnt",   32'(gnt),   32'(exp_gnt));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("rdata", rdata,      exp_rdata);
    chk("oob",   32'(oob),   32'(!r && ref_oob));
    @(posedge clk);
    #1;
    acc = rq && exp_gnt;
    if (r) begin
      pend.delete();
      ref_oob = 1'b0;
    end else if (acc) begin
      off  = a - BASE;
      idx  = int'(off >> 2);
      word = 32'h0;
      if (!(a >= BASE && off < 32'(DEPTH * 4))) begin
        ref_oob = 1'b1;
      end else if (w) begin
        if (ref_mem.exists(idx)) word = ref_mem[idx];
        else word = 'x;
        for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        ref_mem[idx] = word;
        word = 32'h0;
      end else begin
        word = ref_mem.exists(idx) ? ref_mem[idx] : 'x;
      end
      pend.push_back('{due: cyc + int'(LAT), data: word});
    end
    cyc++;
  endtask

  // Repeat a request until accepted, bounded.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
    logic acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cycle(1'b0, 1'b1, w, a, b, d, acc);
    checks++;
    if (!acc) begin
      errors++;
      $error("FAIL xfer_timeout addr=%h observed=not_accepted expected=accepted", a);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    logic [31:0] a;
    if (k == 0)      a = 32'h2000 + 32'($urandom_range(0, 63) * 4);
    else if (k == 1) a = 32'h0FFC - 32'($urandom_range(0, 63) * 4);
    else if (k < 6)  a = BASE + 32'($urandom_range(0, 7) * 4);
    else             a = BASE + 32'((1016 + $urandom_range(0, 7)) * 4);
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic acc;
    int   k;
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   k;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    @(posedge clk);
    #1;
    // Reset held with req high: no grant, outputs at reset values.
    cycle(1'b1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, acc);
    cycle(1'b1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, acc);
    idle(1);

    // Preload the words used by random traffic.
    for (int i = 0; i < 8; i++) xfer(1'b1, BASE + 32'(i * 4), 4'hF, $urandom);
    for (int i = 1016; i < 1024; i++) xfer(1'b1, BASE + 32'(i * 4), 4'hF, $urandom);
    idle(4);

    // Full write then read back.
    xfer(1'b1, BASE + 32'h10, 4'hF, 32'hCAFE_BABE);
    xfer(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    idle(4);

    // Byte enables: expect 0x11BB33DD on read-back.
    xfer(1'b1, BASE + 32'h20, 4'hF,    32'h1122_3344);
    xfer(1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    xfer(1'b0, BASE + 32'h20, 4'h0,    32'h0);
    idle(4);

    // Request held high for six reads: grant throttling, in-order data.
    k = 0;
    for (int n = 0; n < 16; n++) begin
      cycle(1'b0, k < 6, 1'b0, BASE + 32'(k * 4), 4'h0, 32'h0, acc);
      if (acc) k++;
    end
    checks++;
    if (k != 6) begin
      errors++;
      $error("FAIL burst_accepts observed=%0d expected=6", k);
    end

    // Out of range: first word past the end, word below base, last in range.
    xfer(1'b0, 32'h0000_2000, 4'h0, 32'h0);
    xfer(1'b1, 32'h0000_0FFC, 4'hF, 32'hDEAD_BEEF);
    xfer(1'b0, BASE,          4'h0, 32'h0);
    xfer(1'b0, 32'h0000_1FFC, 4'h0, 32'h0);
    xfer(1'b0, 32'h0000_1FFF, 4'h0, 32'h0);
    idle(6);

    // Reset with two reads in flight: both responses discarded.
    xfer(1'b0, BASE + 32'h4, 4'h0, 32'h0);
    xfer(1'b0, BASE + 32'h8, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
    idle(6);

    // Read-after-write on consecutive accepts.
    xfer(1'b1, BASE + 32'h40, 4'hF, 32'h0000_0005);
    xfer(1'b0, BASE + 32'h40, 4'h0, 32'h0);
    idle(4);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom, acc);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
